par2ser_sched: RTL and testbench

//  Round-robin scheduler and sequencer for the shared byte-wide parallel-to-serial shifter.
//  Up to NREQ requesters present a parallel word.
//  The block grants one requester, loads its word, and shifts it out LSB-first, one bit per clk.
//  It then inserts GAP idle cycles and re-arbitrates.

---
 rtl/par2ser_sched.sv | 134 +++++++++++++
 tb/tb_par2ser_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/par2ser_sched.sv
// Round-robin arbiter feeding a shared parallel-to-serial shifter: grant one requester,
// shift its word out LSB-first, idle for GAP cycles, then re-arbitrate.
module par2ser_sched #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int GAP  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*DW-1:0]      data_in,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] src_id,
   output logic                    busy,
   output logic                    ser_valid,
   output logic                    ser_out,
   output logic                    frame_start,
   output logic                    frame_done,
   output logic [1:0]              state_dbg
);
   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(DW);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
   localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bitcnt_q, bitcnt_d;
   logic [GW-1:0] gapcnt_q, gapcnt_d;
   logic [IW-1:0] src_q, src_d;
   logic [IW-1:0] last_q, last_d;

   logic          win_found;
   logic [IW-1:0] win;
   logic [DW-1:0] win_word;

   // Two passes: indices above the pointer first, then wrap around from 0.
   always_comb begin : arbiter
      win_found = 1'b0;
      win       = '0;
      win_word  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && req[i] && (IW'(i) > last_q)) begin
            win_found = 1'b1;
            win       = IW'(i);
            win_word  = data_in[i*DW +: DW];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && req[i] && (IW'(i) <= last_q)) begin
            win_found = 1'b1;
            win       = IW'(i);
            win_word  = data_in[i*DW +: DW];
         end
      end
   end

   always_comb begin : next_state
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      src_d    = src_q;
      last_d   = last_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               shreg_d  = win_word;
               bitcnt_d = '0;
               src_d    = win;
               last_d   = win;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d = {1'b0, shreg_q[DW-1:1]};
            if (bitcnt_q == BIT_LAST) begin
               bitcnt_d = '0;
               state_d  = (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
               bitcnt_d = bitcnt_q + BW'(1);
            end
         end
         S_GAP: begin
            if (gapcnt_q == GAP_LAST) begin
               gapcnt_d = '0;
               state_d  = S_IDLE;
            end else begin
               gapcnt_d = gapcnt_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         src_q    <= '0;
         last_q   <= PTR_RST;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         src_q    <= src_d;
         last_q   <= last_d;
      end
   end

   // grant is Mealy on req; it is held off while rst is high so every output is 0 in reset.
   always_comb begin : outputs
      grant = '0;
      if ((state_q == S_IDLE) && win_found && !rst) grant[win] = 1'b1;
      ser_valid   = (state_q == S_SHIFT);
      ser_out     = ser_valid & shreg_q[0];
      frame_start = ser_valid && (bitcnt_q == '0);
      frame_done  = ser_valid && (bitcnt_q == BIT_LAST);
      busy        = (state_q != S_IDLE);
      src_id      = src_q;
      state_dbg   = state_q;
   end

endmodule

// File: tb/tb_par2ser_sched.sv
// Scoreboarded bench for par2ser_sched: a frame-schedule reference model predicts every
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_par2ser_sched;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int GAP  = 1;
   localparam int IW   = 2;
   localparam int RW   = 16 + NREQ + 5 + IW;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] data_in = '0;
   logic [NREQ-1:0]    grant;
   logic [IW-1:0]      src_id;
   logic busy, ser_valid, ser_out, frame_start, frame_done;
   logic [1:0]         state_dbg;

   par2ser_sched #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) u_dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in), .grant(grant),
      .src_id(src_id), .busy(busy), .ser_valid(ser_valid), .ser_out(ser_out),
      .frame_start(frame_start), .frame_done(frame_done), .state_dbg(state_dbg)
   );

   // second instance: short frames, no gap
   logic        rst2 = 1'b1;
   logic [3:0]  req2 = '0;
   logic [15:0] data2 = '0;
   logic [3:0]  grant2;
   logic [1:0]  src_id2;
   logic busy2, ser_valid2, ser_out2, frame_start2, frame_done2;
   logic [1:0]  state_dbg2;

   par2ser_sched #(.NREQ(4), .DW(4), .GAP(0)) u_dut2 (
      .clk(clk), .rst(rst2), .req(req2), .data_in(data2), .grant(grant2),
      .src_id(src_id2), .busy(busy2), .ser_valid(ser_valid2), .ser_out(ser_out2),
      .frame_start(frame_start2), .frame_done(frame_done2), .state_dbg(state_dbg2)
   );

   // scoreboard state
   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   logic [RW-1:0] exp_q[$];
   logic [18:0]   bit_q[$];

   // reference model state
   int free_at = 0;
   int m_last = NREQ - 1;
   int m_src = 0;
   int last_gcyc = -1;
   int last_gid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [NREQ*DW-1:0] rnd_data();
      logic [NREQ*DW-1:0] d;
      for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
      return d;
   endfunction

   // A frame occupies the cycle after its grant plus DW+GAP more; arbitration happens
   // whenever the line is free and someone requests.
   task automatic model_step();
      logic [NREQ-1:0] g_exp;
      logic [DW-1:0]   word;
      logic [18:0]     bt;
      logic b_exp, sv, so, fs, fd;
      logic [IW-1:0] s_exp;
      int w;
      g_exp = '0;
      sv = 1'b0; so = 1'b0; fs = 1'b0; fd = 1'b0;
      b_exp = (cyc < free_at);
      s_exp = IW'(m_src);
      if (bit_q.size() > 0) begin
         bt = bit_q[0];
         if (bt[18:3] == 16'(cyc)) begin
            void'(bit_q.pop_front());
            sv = 1'b1; fs = bt[2]; fd = bt[1]; so = bt[0];
         end
      end
      if (cyc >= free_at && req != '0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (w < 0 && req[idx]) w = idx;
         end
         g_exp[w] = 1'b1;
         word = data_in[w*DW +: DW];
         for (int b = 0; b < DW; b++)
            bit_q.push_back({16'(cyc + 1 + b), (b == 0), (b == DW - 1), word[b]});
         m_last = w;
         m_src = w;
         free_at = cyc + DW + GAP + 1;
         last_gcyc = cyc;
         last_gid = w;
      end
      exp_q.push_back({16'(cyc), g_exp, b_exp, sv, so, fs, fd, s_exp});
   endtask

   // driver tasks
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
      @(posedge clk);
      #1;
      cyc++;
      req = r;
      data_in = d;
      model_step();
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      req = '0;
      free_at = cyc;
      m_last = NREQ - 1;
      m_src = 0;
      exp_q.delete();
      bit_q.delete();
      model_step();
      mon_en = 1'b1;
   endtask

   task automatic reset_mid_frame();
      int tries;
      tries = 0;
      last_gcyc = -1;
      while (last_gcyc != cyc && tries < 40) begin
         step(4'b0001, rnd_data());
         tries++;
      end
      if (last_gcyc != cyc) begin
         n_vec++;
         n_bad++;
         $display("FAIL midrst_grant_timeout cyc=%0d got=none exp=grant", cyc);
      end else begin
         while (cyc < last_gcyc + 5) step('0, rnd_data());
         chk("midrst_pre_valid", ser_valid, 1'b1);
         #2;
         mon_en = 1'b0;
         rst = 1'b1;
         #1;
         chk("midrst_ser_valid", ser_valid, 1'b0);
         chk("midrst_busy", busy, 1'b0);
         chk("midrst_ser_out", ser_out, 1'b0);
         chk("midrst_grant", grant, '0);
         exp_q.delete();
         bit_q.delete();
         @(posedge clk);
         @(posedge clk);
         release_rst();
         step(4'b0110, rnd_data());
      end
   endtask

   task automatic run_gap0();
      logic [3:0] w6;
      logic [3:0] g_e;
      logic v_e, o_e;
      w6 = 4'hC;
      @(posedge clk);
      #1;
      rst2 = 1'b0;
      req2 = 4'b1000;
      data2 = {w6, 12'($urandom)};
      for (int k = 0; k < 15; k++) begin
         g_e = (k % 5 == 0) ? 4'b1000 : 4'b0000;
         v_e = (k % 5 != 0);
         o_e = v_e ? w6[(k % 5) - 1] : 1'b0;
         @(negedge clk);
         chk("gap0_grant", grant2, g_e);
         chk("gap0_ser_valid", ser_valid2, v_e);
         chk("gap0_ser_out", ser_out2, o_e);
         @(posedge clk);
         #1;
         data2[11:0] = 12'($urandom);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      logic [RW-1:0] e;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL exp_underflow cyc=%0d got=empty exp=record", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("grant", grant, e[IW+5 +: NREQ]);
            chk("busy", busy, e[IW+4]);
            chk("ser_valid", ser_valid, e[IW+3]);
            chk("ser_out", ser_out, e[IW+2]);
            chk("frame_start", frame_start, e[IW+1]);
            chk("frame_done", frame_done, e[IW]);
            chk("src_id", src_id, e[IW-1:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0]    pend;
      logic [NREQ*DW-1:0] hold;
      logic [NREQ*DW-1:0] d0;

      req = 4'hF;
      data_in = rnd_data();
      #3;
      chk("rst_grant", grant, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ser_valid", ser_valid, 1'b0);
      chk("rst_ser_out", ser_out, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_src_id", src_id, '0);
      @(posedge clk);
      release_rst();

      // single requester, word 0xA5
      d0 = rnd_data();
      d0[DW-1:0] = 8'hA5;
      step(4'b0001, d0);
      repeat (11) step('0, rnd_data());

      // all requesting, data held
      hold = rnd_data();
      repeat (45) step(4'hF, hold);

      // free-running random req/data, including changes mid-frame
      repeat (300) step(NREQ'($urandom_range(0, 15)), rnd_data());

      // requesters hold req and data until granted
      pend = '0;
      hold = rnd_data();
      repeat (300) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               hold[i*DW +: DW] = DW'($urandom_range(0, 255));
            end
         end
         step(pend, hold);
         if (last_gcyc == cyc) pend[last_gid] = 1'b0;
      end

      reset_mid_frame();
      repeat (100) step(NREQ'($urandom_range(0, 15)), rnd_data());
      step('0, rnd_data());
      @(posedge clk);
      mon_en = 1'b0;
      chk("queue_drain", exp_q.size(), 0);

      run_gap0();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
